// File: rtl/mcp_pkg.sv
// mcp_pkg: shared definitions for the multicycle MIPS controller.
//   - state_t    : FSM state encodings (FETCH..BNEEX)
//   - OP_*       : instruction opcodes (instr[31:26])
//   - FN_*       : R-type funct codes (instr[5:0])
//   - ALU_*      : ALU function codes driven on alucontrol
//   - aluop_t    : ALU operation class from the FSM to the ALU decoder
//   - alu_decode : (aluop, funct) -> alucontrol helper used by aludec
package mcp_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  // Unrecognised funct codes fall back to add so the ALU code is never X.
  function automatic logic [2:0] alu_decode(input aluop_t aluop, input logic [5:0] funct);
    logic [2:0] f;
    f = ALU_ADD;
    case (aluop)
      ALUOP_ADD: f = ALU_ADD;
      ALUOP_SUB: f = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  f = ALU_ADD;
          FN_SUB:  f = ALU_SUB;
          FN_AND:  f = ALU_AND;
          FN_OR:   f = ALU_OR;
          FN_SLT:  f = ALU_SLT;
          default: f = ALU_ADD;
        endcase
      end
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mcp_controller_if.sv
// mcp_controller_if: bundle between the controller and the mcp datapath.
//   Datapath -> controller : op, funct, zero
//   Controller -> datapath : pcen, memwrite, irwrite, regwrite, alusrca,
//                            alusrcb, iord, memtoreg, regdst, pcsrc,
//                            alucontrol, state (debug)
//   modport master : controller side
//   modport slave  : datapath side
interface mcp_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
           memtoreg, regdst, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
           memtoreg, regdst, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mcp_controller_aludec.sv
// aludec: combinational ALU decoder.
//   aluop      : operation class from the controller FSM
//   funct      : instr[5:0], consulted only for R-type
//   alucontrol : 3-bit ALU function code
module aludec
  import mcp_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Map aluop/funct to the ALU function code.
  always_comb begin
    alucontrol = alu_decode(aluop, funct);
  end

endmodule

// File: rtl/mcp_controller.sv
// mcp_controller: multicycle MIPS control unit (Moore FSM + ALU decoder).
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset; also gates all write enables
//   bus     : mcp_controller_if.master (opcode/funct/zero in; datapath
//             enables, mux selects, alucontrol and debug state out)
// Optional build macro MCP_BNE_EN adds the bne instruction (BNEEX state);
// without it opcode 000101 is treated as an unknown opcode.
module mcp_controller
  import mcp_pkg::*;
#(
  parameter int                 STATE_W     = 4,
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
  input  logic                clk,
  input  logic                reset_n,
  mcp_controller_if.master    bus
);

  logic [STATE_W-1:0] state_r;

  logic   pcwrite_s;
  logic   branch_s;
  logic   bne_s;
  logic   irwrite_s;
  logic   regwrite_s;
  logic   memwrite_s;
  logic   alusrca_s;
  logic [1:0] alusrcb_s;
  logic   iord_s;
  logic   memtoreg_s;
  logic   regdst_s;
  logic [1:0] pcsrc_s;
  aluop_t aluop_s;
  logic [2:0] alucontrol_s;

  // FSM state register and next-state sequencing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= RESET_STATE;
    end else begin
      case (state_r)
        S_FETCH: state_r <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_r <= S_MEMADR;
            OP_RTYPE:     state_r <= S_RTYPEEX;
            OP_BEQ:       state_r <= S_BEQEX;
            OP_ADDI:      state_r <= S_ADDIEX;
            OP_J:         state_r <= S_JEX;
`ifdef MCP_BNE_EN
            OP_BNE:       state_r <= S_BNEEX;
`endif
            default:      state_r <= S_FETCH;
          endcase
        end
        // Only lw and sw reach MEMADR, so anything but sw is a load.
        S_MEMADR:  state_r <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state_r <= S_MEMWB;
        S_RTYPEEX: state_r <= S_RTYPEWB;
        S_ADDIEX:  state_r <= S_ADDIWB;
        // Terminal states and unused codes all return to FETCH.
        default:   state_r <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    bne_s      = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    iord_s     = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    pcsrc_s    = 2'b00;
    aluop_s    = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb_s = 2'b01;
      end
      S_DECODE: alusrcb_s = 2'b11;
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: iord_s = 1'b1;
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
      end
      S_BEQEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = 2'b01;
        branch_s  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
`ifdef MCP_BNE_EN
      S_BNEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = 2'b01;
        bne_s     = 1'b1;
      end
`endif
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Write enables are suppressed while reset is held so an abandoned
  // instruction cannot commit anything.
  always_comb begin
    if (!reset_n) begin
      bus.pcen     = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.memwrite = 1'b0;
    end else begin
      bus.pcen     = pcwrite_s | (branch_s & bus.zero) | (bne_s & ~bus.zero);
      bus.irwrite  = irwrite_s;
      bus.regwrite = regwrite_s;
      bus.memwrite = memwrite_s;
    end
  end

  aludec u_aludec (
    .aluop      (aluop_s),
    .funct      (bus.funct),
    .alucontrol (alucontrol_s)
  );

  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.iord       = iord_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.regdst     = regdst_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.alucontrol = alucontrol_s;
  assign bus.state      = state_r;

endmodule

// File: doc/mcp_controller.md
Name: mcp_controller

Overview:
- Multicycle MIPS control unit; it is the producer of the ALU's 3-bit function code `f`.
- Moore FSM that sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives datapath enables and muxes, and generates `alucontrol` through an ALU decoder from `aluop` and `funct`.
- Sits between the instruction register and the mcp datapath/ALU; consumes the ALU `zero` flag for branches.

Parameters:
- STATE_W, 4, width of the state register.
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous reset, active-low
- op  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag from the current cycle
- pcen  output  1  PC write enable
- memwrite  output  1  memory write
- irwrite  output  1  instruction register write
- regwrite  output  1  register file write
- alusrca  output  1  0=PC, 1=A
- alusrcb  output  2  00=B, 01=4, 10=signimm, 11=signimm<<2
- iord  output  1  0=PC, 1=ALUOut address
- memtoreg  output  1  0=ALUOut, 1=Data
- regdst  output  1  0=rt, 1=rd
- pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU `f`
- state  output  4  current state, for debug

Behaviour:
- **Reset**
  - Clock and reset: one clock `clk`; reset `reset_n` is synchronous and active-low.
  - `reset_n`=0 at a rising edge sets state to FETCH.
  - While `reset_n`=0, `pcen`, `memwrite`, `irwrite` and `regwrite` are forced to 0 combinationally.
  - All other outputs decode from the state register.
  - Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- **State encoding**
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12 (optional).
  - Codes 13–15 go to FETCH on the next edge, with all enables 0.
- **Transitions** (one edge each)
  - FETCH → DECODE.
  - DECODE by opcode:
    - lw(100011) or sw(101011) → MEMADR.
    - R-type(000000) → RTYPEEX.
    - beq(000100) → BEQEX.
    - addi(001000) → ADDIEX.
    - j(000010) → JEX.
    - Any other opcode → FETCH (instruction treated as a NOP).
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - RTYPEEX → RTYPEWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.
- **Moore outputs** (all outputs not listed are 0)
  - FETCH: `irwrite`=1, pcwrite=1, `alusrcb`=01, aluop=00.
  - DECODE: `alusrcb`=11, aluop=00.
  - MEMADR: `alusrca`=1, `alusrcb`=10, aluop=00.
  - MEMRD: `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, aluop=10.
  - RTYPEWB: `regwrite`=1, `regdst`=1.
  - BEQEX: `alusrca`=1, aluop=01, `pcsrc`=01, branch=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, pcwrite=1.
- **PC enable**: `pcen` = pcwrite | (branch & `zero`) [| (bne & ~`zero`)]; `zero` is sampled combinationally in BEQEX/BNEEX.
- **ALU decoder** (combinational)
  - aluop 00 → 010 (add).
  - aluop 01 → 110 (sub).
  - aluop 10 by funct:
    - 100000 → 010 (add).
    - 100010 → 110 (sub).
    - 100100 → 000 (and).
    - 100101 → 001 (or).
    - 101010 → 111 (slt).
    - Any other funct → 010; RTYPEWB still writes the result.
  - aluop 11 → 010.
  - Output never X.

Optional Feature:
- Macro: MCP_BNE_EN.
- Defined:
  - DECODE with op=000101 → BNEEX.
  - BNEEX drives the same outputs as BEQEX except branch=0 and bne=1; `pcen` = ~`zero`.
  - BNEEX → FETCH.
- Undefined:
  - op 000101 is an unknown opcode (DECODE → FETCH).
  - The BNEEX state code is unused and handled like 13–15.

Decomposition:
- Shared package `mcp_pkg`:
  - State encodings.
  - Opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J/OP_BNE.
  - Funct constants.
  - ALU codes ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111.
  - aluop codes.
- Sub-module `aludec`: combinational (aluop, funct) → `alucontrol`, instantiated inside `mcp_controller`.
- The FSM plus output decode stays in the top module.

Test Plan:
- Reset: hold `reset_n`=0 for 2 edges → `state`=0 and `pcen`=`irwrite`=`regwrite`=`memwrite`=0. Release `reset_n` → `pcen`=1, `irwrite`=1, `alucontrol`=010.
- R-type: op=000000, funct=100010 → state sequence 0,1,6,7,0. In state 6 `alucontrol`=110. In state 7 `regwrite`=1, `regdst`=1.
- Load: lw op=100011 → states 0,1,2,3,4,0. State 3 has `iord`=1. State 4 has `regwrite`=1, `memtoreg`=1.
- Store: sw op=101011 → states 0,1,2,5,0; only state 5 has `memwrite`=1.
- beq: op=000100 → state 8 with `alucontrol`=110. With `zero`=1 → `pcen`=1; with `zero`=0 → `pcen`=0. Next state 0 in both cases.
- Reset and unknown inputs:
  - `reset_n`=0 asserted in state 3 → next state 0, with no `regwrite` after that edge.
  - op=111111 → states 0,1,0.
  - With MCP_BNE_EN defined, op=000101 and `zero`=0 → `pcen`=1 in state 12.
